mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have the port `clk  in  1` as the rising-edge clock.
REQ-002 SHALL have the port `n_rst  in  1` as the reset: asynchronous, active-low.
REQ-003 SHALL have the port `if_req  in  1` as the fetch request; the requester holds it until `if_done`.
REQ-004 SHALL have the port `if_addr  in  32` as the fetch address (PC), sampled at grant.
REQ-005 SHALL have the port `if_flush  in  1` to cancel the current or pending fetch (branch, jump, exception or irq redirect).
REQ-006 SHALL have the port `if_done  out  1` as a one-cycle fetch-complete pulse.
REQ-007 SHALL have the port `if_rdata  out  32` as the fetched instruction, valid while `if_done`=1.
REQ-008 SHALL have the port `stall_if  out  1` as the fetch stall, routed to the fetch-stage stall input.
REQ-009 SHALL have the port `d_req  in  1` as the data access request; the requester holds it until `d_done`.
REQ-010 SHALL have the port `d_we  in  1` as the write enable (1=store, 0=load), sampled at grant.
REQ-011 SHALL have the port `d_addr  in  32` as the data address, sampled at grant.
REQ-012 SHALL have the port `d_wdata  in  32` as the store data, sampled at grant.
REQ-013 SHALL have the port `d_done  out  1` as a one-cycle data-complete pulse.
REQ-014 SHALL have the port `d_rdata  out  32` as the load data, valid while `d_done`=1; it reads 0 on stores.
REQ-015 SHALL have the port `stall_d  out  1` as the data-stage stall.
REQ-016 SHALL have the port `mem_req  out  1` as the single-port memory request.
REQ-017 SHALL have the ports `mem_we  out  1`, `mem_addr  out  32` and `mem_wdata  out  32` as the memory command.
REQ-018 SHALL have the ports `mem_rdata  in  32` and `mem_ack  in  1` as the memory response; `mem_ack` completes the access in the cycle it is seen with `mem_req`=1.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY_IF, BUSY_D and DONE.
REQ-020 IDLE: `d_req`=1 → BUSY_D, else `if_req`=1 and `if_flush`=0 → BUSY_IF, else stay IDLE; this is subject to REQ-021.
REQ-021 SHALL keep a 2-bit count of consecutive data grants; when the count is 2 and `if_req`=1 (no flush), IDLE SHALL grant IF even if `d_req`=1.
REQ-022 The consecutive-grant count SHALL increment on each D grant, saturating at 2, and clear on each IF grant.
REQ-023 On a grant, SHALL register the address, we and wdata; `mem_req` SHALL go to 1 in the following cycle.
REQ-024 `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` SHALL be registered outputs, stable from grant until the ack cycle.
REQ-025 BUSY_x with `mem_ack`=1 → DONE; `mem_req` SHALL be 0 in DONE.
REQ-026 BUSY_x with `mem_ack`=0 → stay in BUSY_x; there is no timeout.
REQ-027 SHALL capture `mem_rdata` into `if_rdata` or `d_rdata` on ack, and hold it until the next completion.
REQ-028 DONE SHALL pulse `if_done` or `d_done` for exactly one cycle, then → IDLE.
REQ-029 Requests SHALL NOT be sampled in DONE, so the completing requester can retire.
REQ-030 Minimum access latency: grant at cycle N, ack at N+1, done at N+2, next grant at N+3.
REQ-031 SHALL compute `stall_if` = `if_req` & ~`if_done` and `stall_d` = `d_req` & ~`d_done`, combinationally.
REQ-032 `if_flush` in BUSY_IF SHALL set a drop flag; the access SHALL complete on the memory side, but DONE SHALL NOT pulse `if_done`.
REQ-033 The drop flag SHALL clear on entry to IDLE.
REQ-034 `if_flush` in IDLE SHALL suppress an IF grant that cycle; a D grant that cycle is unaffected.
REQ-035 `if_flush` SHALL have no effect in BUSY_D or DONE for a data access.
REQ-036 SHALL never issue an access for a requester whose req is 0 in the grant cycle.
REQ-037 Arithmetic: SHALL pass addresses through unmodified; the arbiter does no alignment or translation.

Reset
REQ-038 `n_rst`=0 SHALL force immediately: state IDLE, `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, `if_rdata`/`d_rdata`=0, `if_done`/`d_done`=0, count 0, drop flag 0.
REQ-039 Reset during BUSY_x SHALL abandon the access; an ack arriving after reset deassertion with `mem_req`=0 SHALL be ignored.
REQ-040 After reset release, the first grant SHALL follow REQ-020 on the first rising edge.

Verification
REQ-041 Fetch only: `if_req`=1, `if_addr`=0x00000010, memory acks next cycle with 0x83FFF800 → `mem_req` at N+1, `if_done`=1 and `if_rdata`=0x83FFF800 at N+2, `stall_if`=0 at N+2.
REQ-042 Simultaneous: `if_req`=`d_req`=1, load from 0x100 → D served first, `stall_if`=1 throughout, then IF served after DONE.
REQ-043 Starvation: `d_req` held high with back-to-back loads plus `if_req`=1 → grant order D, D, IF, D, D, IF.
REQ-044 Flush: `if_flush` pulsed in BUSY_IF, ack after 3 wait cycles → no `if_done`, IDLE thereafter, the next fetch with the new PC completes normally.
REQ-045 Store: `d_we`=1, `d_addr`=0x200, `d_wdata`=0xDEADBEEF → `mem_we`=1 with the stable command until ack, `d_done` pulse, `d_rdata`=0.
REQ-046 Reset mid-access: `n_rst`=0 in BUSY_D → `mem_req`=0 immediately; a late ack produces no done pulse; post-reset fetch completes.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and single-port memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if;
    // fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        stall_if;
    // data requester
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        stall_d;
    // memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_done, if_rdata, stall_if,
        output d_done, d_rdata, stall_d,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_done, if_rdata, stall_if,
        input  d_done, d_rdata, stall_d,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory.
// Ports: clk, n_rst (async active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter (
    input  logic                clk,
    input  logic                n_rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] d_cnt;
    logic       drop;

    logic if_prio;
    logic grant_if;
    logic grant_d;
    logic ack_if;
    logic ack_d;
    logic if_keep;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        // After two back-to-back data grants a waiting fetch wins once.
        if_prio  = (d_cnt == 2'd2) && bus.if_req && !bus.if_flush;
        grant_d  = (state == IDLE) && bus.d_req && !if_prio;
        grant_if = (state == IDLE) && bus.if_req && !bus.if_flush
                   && !grant_d;
        ack_if   = (state == BUSY_IF) && bus.mem_ack;
        ack_d    = (state == BUSY_D) && bus.mem_ack;
        // A flush landing in the ack cycle cancels the fetch as well.
        if_keep  = !drop && !bus.if_flush;
        bus.stall_if = bus.if_req & ~bus.if_done;
        bus.stall_d  = bus.d_req & ~bus.d_done;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_done   <= 1'b0;
            bus.d_done    <= 1'b0;
            d_cnt         <= 2'd0;
            drop          <= 1'b0;
        end else begin
            bus.if_done <= ack_if && if_keep;
            bus.d_done  <= ack_d;

            if (grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
                d_cnt         <= (d_cnt == 2'd2) ? 2'd2 : d_cnt + 2'd1;
            end else if (grant_if) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
                d_cnt         <= 2'd0;
            end else if (ack_if || ack_d) begin
                bus.mem_req   <= 1'b0;
            end

            if (ack_d) begin
                bus.d_rdata <= bus.mem_we ? 32'd0 : bus.mem_rdata;
            end
            if (ack_if && if_keep) begin
                bus.if_rdata <= bus.mem_rdata;
            end

            if (state == DONE) begin
                drop <= 1'b0;
            end else if (state == BUSY_IF && bus.if_flush) begin
                drop <= 1'b1;
            end
        end
    end

endmodule
